ic_bvmul_sge_sweeper: RTL and testbench

- Sequential checker for the bvmul/bvsge invertibility condition (IC): "there exists x such that (x*s mod 2^W) >=s t".
- Accepts an (s,t) query and latches it. Presents the query to an external combinational IC/Skolem block, then sweeps x exhaustively, one candidate per cycle, to find a witness.
- Reports the witness, whether one was found, and whether the external IC prediction disagrees with the sweep.
- Sits between a query source (testbench or enumerator) and the generated IC netlists as their checking scheduler.

---
 rtl/ic_bvmul_sge_sweeper_pkg.sv | 22 ++
 rtl/ic_eval_core.sv | 21 ++
 rtl/ic_bvmul_sge_sweeper.sv | 133 +++++++++++++
 tb/tb_ic_bvmul_sge_sweeper.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ic_bvmul_sge_sweeper_pkg.sv
// ic_sweep_pkg: shared types and helpers for the bvmul/bvsge IC sweeper.
//   state_t  : sweeper FSM states
//   W_DEF    : default operand width
//   SW_DEF   : default statistics counter width
//   sge_w()  : W-bit two's complement a >= b, with operands zero-extended to 32 bits
package ic_sweep_pkg;

    localparam int unsigned W_DEF  = 4;
    localparam int unsigned SW_DEF = 16;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    // Flipping the sign bit maps two's complement onto offset binary, so an
    // unsigned compare of the flipped values is the signed compare.
    function automatic logic sge_w(input logic [31:0] a, input logic [31:0] b,
                                   input int unsigned w);
        logic [31:0] bias;
        bias = 32'd1 << (w - 1);
        return (a ^ bias) >= (b ^ bias);
    endfunction

endpackage

// File: rtl/ic_eval_core.sv
// ic_eval_core: combinational evaluation of one sweep candidate.
//   s, x, t : operand, candidate, signed bound (W bits each)
//   hit     : signed((x*s) mod 2^W) >= signed(t)
module ic_eval_core
    import ic_sweep_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic [W-1:0] s,
    input  logic [W-1:0] x,
    input  logic [W-1:0] t,
    output logic         hit
);

    logic [W-1:0] prod;

    // W-bit result context truncates the product mod 2^W
    assign prod = s * x;
    assign hit  = sge_w(32'(prod), 32'(t), W);

endmodule

// File: rtl/ic_bvmul_sge_sweeper.sv
// ic_bvmul_sge_sweeper: exhaustive witness sweep for the bvmul/bvsge
// invertibility condition, scheduling checks of an external IC block.
//   req_*   : query handshake (s, t)
//   ic_s/t  : latched query to the external IC block, ic_a its prediction
//   resp_*  : result handshake (found, smallest x, candidates tested, mismatch)
//   stat_*  : saturating completed/mismatch counters, stat_clear clears both
module ic_bvmul_sge_sweeper
    import ic_sweep_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned SW = SW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [W-1:0]  req_s,
    input  logic [W-1:0]  req_t,
    output logic [W-1:0]  ic_s,
    output logic [W-1:0]  ic_t,
    input  logic          ic_a,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_found,
    output logic [W-1:0]  resp_x,
    output logic [W:0]    resp_tested,
    output logic          resp_mismatch,
    output logic [SW-1:0] stat_checks,
    output logic [SW-1:0] stat_mism,
    input  logic          stat_clear
);

    localparam logic [W-1:0] XMAX = '1;

    state_t       state;
    logic [W-1:0] s_q, t_q, x_cnt;
    logic         first_q;
    logic         ic_pred;
    logic         hit;
    logic         resp_hs;

    ic_eval_core #(.W(W)) u_eval (
        .s   (s_q),
        .x   (x_cnt),
        .t   (t_q),
        .hit (hit)
    );

    assign ic_s          = s_q;
    assign ic_t          = t_q;
    assign req_ready     = (state == IDLE);
    assign resp_mismatch = resp_found ^ ic_pred;
    assign resp_hs       = resp_valid & resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            s_q         <= '0;
            t_q         <= '0;
            x_cnt       <= '0;
            first_q     <= 1'b0;
            ic_pred     <= 1'b0;
            resp_valid  <= 1'b0;
            resp_found  <= 1'b0;
            resp_x      <= '0;
            resp_tested <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        s_q         <= req_s;
                        t_q         <= req_t;
                        x_cnt       <= '0;
                        first_q     <= 1'b1;
                        ic_pred     <= 1'b0;
                        resp_found  <= 1'b0;
                        resp_x      <= '0;
                        resp_tested <= '0;
                        state       <= SWEEP;
                    end
                end
                SWEEP: begin
                    // the IC block sees a stable query only from the first
                    // sweep cycle on, so its answer is taken exactly once there
                    if (first_q) begin
                        ic_pred <= ic_a;
                        first_q <= 1'b0;
                    end
                    if (hit) begin
                        resp_found  <= 1'b1;
                        resp_x      <= x_cnt;
                        resp_tested <= {1'b0, x_cnt} + (W+1)'(1);
                        state       <= DONE;
                    end else if (x_cnt == XMAX) begin
                        resp_found  <= 1'b0;
                        resp_x      <= '0;
                        resp_tested <= {1'b1, {W{1'b0}}};
                        state       <= DONE;
                    end else begin
                        x_cnt <= x_cnt + W'(1);
                    end
                end
                DONE: begin
                    // resp_valid trails DONE entry by one edge so the result
                    // registers settle a full cycle before being offered
                    if (resp_hs) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        resp_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_checks <= '0;
            stat_mism   <= '0;
        end else if (stat_clear) begin
            stat_checks <= '0;
            stat_mism   <= '0;
        end else if (resp_hs) begin
            if (stat_checks != '1)
                stat_checks <= stat_checks + SW'(1);
            if (resp_mismatch && stat_mism != '1)
                stat_mism <= stat_mism + SW'(1);
        end
    end

endmodule

// File: tb/tb_ic_bvmul_sge_sweeper.sv
// Bench for ic_bvmul_sge_sweeper: directed test-plan queries with literal
// expectations, a reset abort, then every (s,t) pair with random IC
// predictions, hold times and clears, against an integer-arithmetic model.
module tb_ic_bvmul_sge_sweeper;

    localparam int W  = 4;
    localparam int SW = 4;
    localparam int N  = 1 << W;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk, rst_n;
    logic          req_valid, req_ready;
    logic [W-1:0]  req_s, req_t, ic_s, ic_t;
    logic          ic_a;
    logic          resp_valid, resp_ready, resp_found, resp_mismatch;
    logic [W-1:0]  resp_x;
    logic [W:0]    resp_tested;
    logic [SW-1:0] stat_checks, stat_mism;
    logic          stat_clear;

    ic_bvmul_sge_sweeper #(.W(W), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_s(req_s), .req_t(req_t),
        .ic_s(ic_s), .ic_t(ic_t), .ic_a(ic_a),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_found(resp_found), .resp_x(resp_x),
        .resp_tested(resp_tested), .resp_mismatch(resp_mismatch),
        .stat_checks(stat_checks), .stat_mism(stat_mism),
        .stat_clear(stat_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscomp = 0;
    int m_checks = 0;
    int m_mism = 0;

    typedef struct {
        int found;
        int x;
        int tested;
        int mism;
        int acc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscomp++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Smallest x in 0..N-1 whose truncated product, read as signed, is >= signed t.
    function automatic void model(input int s, input int t,
                                  output int found, output int x, output int tested);
        int p, ts;
        found = 0; x = 0; tested = N;
        ts = (t >= N/2) ? t - N : t;
        for (int i = 0; i < N; i++) begin
            p = (s * i) % N;
            if (p >= N/2) p = p - N;
            if (p >= ts) begin
                found = 1; x = i; tested = i + 1;
                return;
            end
        end
    endfunction

    // Response monitor: latency on the rising edge of resp_valid, and every
    // output held against the expected result for as long as it stays valid.
    logic prev_v = 1'b0;
    logic have_cur = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v   = 1'b0;
            have_cur = 1'b0;
        end else begin
            if (resp_valid && !prev_v) begin
                if (q.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                    have_cur = 1'b0;
                end else begin
                    cur = q.pop_front();
                    have_cur = 1'b1;
                    chk("latency", cyc - cur.acc, cur.tested + 1);
                end
            end
            if (resp_valid && have_cur) begin
                chk("resp_found", resp_found, cur.found);
                chk("resp_x", resp_x, cur.x);
                chk("resp_tested", resp_tested, cur.tested);
                chk("resp_mismatch", resp_mismatch, cur.mism);
                chk("req_ready_done", req_ready, 0);
            end
            prev_v = resp_valid;
        end
    end

    task automatic accept(input int s, input int t, input int a, input int f, input int x, input int te);
        exp_t e;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_s = W'(s); req_t = W'(t); ic_a = a[0];
        @(negedge clk);
        req_valid = 1'b0;
        e.found = f; e.x = x; e.tested = te; e.mism = f ^ a; e.acc = cyc;
        q.push_back(e);
        chk("ic_s", ic_s, s);
        chk("ic_t", ic_t, t);
        chk("req_ready_sweep", req_ready, 0);
    endtask

    task automatic query(input int s, input int t, input int a, input int hold, input int clr,
                         input int lit, input int efound, input int ex, input int etested);
        int f, x, te, n;
        model(s, t, f, x, te);
        if (lit != 0) begin
            chk("model_found", f, efound);
            chk("model_x", x, ex);
            chk("model_tested", te, etested);
        end
        accept(s, t, a, f, x, te);
        // past the first sweep cycle the prediction must no longer matter
        @(negedge clk);
        ic_a = 1'($urandom_range(0, 1));
        n = 0;
        while (!resp_valid && n < 2*N) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            chk("resp_timeout", 0, 1);
            return;
        end
        repeat (hold) begin
            chk("stat_checks_hold", stat_checks, m_checks);
            chk("stat_mism_hold", stat_mism, m_mism);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        stat_clear = clr[0];
        @(negedge clk);
        resp_ready = 1'b0;
        stat_clear = 1'b0;
        if (clr != 0) begin
            m_checks = 0; m_mism = 0;
        end else begin
            if (m_checks < SMAX) m_checks++;
            if ((f ^ a) != 0 && m_mism < SMAX) m_mism++;
        end
        chk("resp_valid_after_hs", resp_valid, 0);
        chk("req_ready_after_hs", req_ready, 1);
        chk("stat_checks", stat_checks, m_checks);
        chk("stat_mism", stat_mism, m_mism);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_found"}, resp_found, 0);
        chk({tag, "_resp_mismatch"}, resp_mismatch, 0);
        chk({tag, "_resp_x"}, resp_x, 0);
        chk({tag, "_resp_tested"}, resp_tested, 0);
        chk({tag, "_ic_s"}, ic_s, 0);
        chk({tag, "_ic_t"}, ic_t, 0);
        chk({tag, "_stat_checks"}, stat_checks, 0);
        chk({tag, "_stat_mism"}, stat_mism, 0);
    endtask

    initial begin
        int f, x, te;
        rst_n = 1'b0; req_valid = 1'b0; req_s = '0; req_t = '0; ic_a = 1'b0;
        resp_ready = 1'b0; stat_clear = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;

        query(0, 0, 1, 0, 0, 1, 1, 0, 1);
        query(0, 1, 0, 0, 0, 1, 0, 0, 16);
        query(1, 7, 1, 0, 0, 1, 1, 7, 8);
        query(2, 7, 0, 0, 0, 1, 0, 0, 16);
        query(2, 7, 1, 0, 1, 1, 0, 0, 16);
        query(2, 7, 1, 0, 0, 1, 0, 0, 16);
        chk("lit_stat_checks", stat_checks, 1);
        chk("lit_stat_mism", stat_mism, 1);
        query(0, 0, 0, 0, 1, 1, 1, 0, 1);
        chk("lit_clear_checks", stat_checks, 0);
        chk("lit_clear_mism", stat_mism, 0);
        query(1, 7, 0, 10, 0, 1, 1, 7, 8);
        query(5, 12, 1, 0, 0, 0, 0, 0, 0);

        // abort in the fifth sweep cycle
        model(0, 1, f, x, te);
        accept(0, 1, 1, f, x, te);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks("abort");
        q.delete();
        m_checks = 0; m_mism = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_resp", resp_valid, 0);

        query(3, 5, 0, 0, 0, 1, 1, 2, 3);

        for (int s = 0; s < N; s++)
            for (int t = 0; t < N; t++)
                query(s, t, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                      ($urandom_range(0, 40) == 0) ? 1 : 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

endmodule
